xbit_delay_detector: RTL and testbench

- Receive-side companion to the variable bit-delay shifter.
- Observes the reference stream fed into the shifter (ref_bit) and the shifter's delayed output (dly_bit).
- Determines which programmed delay length 0..MAX_LEN is active, reports it as lag, holds lock, and flags loss of lock when the delay changes (e.g. after a button step).
- Sits beside the shifter in the top-level self-test path.

---
 rtl/xbit_delay_detector.sv | 229 ++++++++++++++++++++++
 tb/tb_xbit_delay_detector.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xbit_delay_detector.sv
// rtl/xbit_delay_detector.sv - detects the active lag of the variable bit-delay shifter
module xbit_delay_detector #(
    parameter  int MAX_LEN = 15,
    parameter  int OFFSET  = 2,
    parameter  int WIN     = 32,
    parameter  int LOSS    = 4,
    parameter  int TIMEOUT = 1024,
    localparam int LEN_W   = (MAX_LEN < 1) ? 1 : $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ref_bit,
    input  logic             dly_bit,
    output logic [LEN_W-1:0] lag,
    output logic             locked,
    output logic             busy,
    output logic             lost_pulse,
    output logic             fail_pulse
);

    localparam int HIST_D = MAX_LEN + OFFSET + 1;
    localparam int CNT_W  = $clog2(WIN + 1);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int FILL_W = $clog2(HIST_D + 1);
    localparam int WIN_W  = $clog2(WIN);
    localparam int MISS_W = $clog2(LOSS + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(WIN);
    localparam logic [CNT_W-1:0]  CNT_LOCK  = CNT_W'(WIN - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(HIST_D - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN - 1);
    localparam logic [MISS_W-1:0] MISS_LOSS = MISS_W'(LOSS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_SEARCH,
        S_LOCKED
    } state_t;

    state_t state, state_n;

    // Input stage and reference history; hist[0] is the registered ref_bit.
    logic                ref_s;
    logic                dly_s;
    logic [HIST_D-1:1]   hist_q;
    logic [HIST_D-1:0]   hist;
    logic [MAX_LEN:0]    match;

    // Per-lag run counters and control counters.
    logic [CNT_W-1:0]    cnt   [MAX_LEN+1];
    logic [CNT_W-1:0]    cnt_n [MAX_LEN+1];
    logic [FILL_W-1:0]   fill_cnt, fill_n;
    logic [TMO_W-1:0]    tmo_cnt, tmo_n;
    logic [WIN_W-1:0]    win_cnt, win_n;
    logic [MISS_W-1:0]   miss_cnt, miss_n, miss_sum;
    logic [LEN_W-1:0]    lag_n;
    logic                locked_n;
    logic                lost_n;
    logic                fail_n;

    logic                hit;
    logic [LEN_W-1:0]    hit_k;
    logic                miss_now;
    logic                wrap;

    assign hist = {hist_q, ref_s};

    // Register both streams once and shift the reference into the history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_s  <= 1'b0;
            dly_s  <= 1'b0;
            hist_q <= '0;
        end else begin
            ref_s  <= ref_bit;
            dly_s  <= dly_bit;
            hist_q <= hist[HIST_D-2:0];
        end
    end

    // Compare the delayed stream against every candidate tap, skipping the fixed pipeline latency.
    always_comb begin
        match = '0;
        for (int k = 0; k <= MAX_LEN; k++) begin
            match[k] = (dly_s == hist[k + OFFSET]);
        end
    end

    // Find the lowest lag whose run is about to reach WIN; scanning downward leaves the lowest.
    always_comb begin
        hit   = 1'b0;
        hit_k = '0;
        for (int k = MAX_LEN; k >= 0; k--) begin
            if (cnt[k] == CNT_LOCK && match[k]) begin
                hit   = 1'b1;
                hit_k = LEN_W'(k);
            end
        end
    end

    assign miss_now = ~match[lag];
    assign wrap     = (win_cnt == WIN_LAST);

    // Next-state and next-output logic; start overrides everything.
    always_comb begin
        state_n  = state;
        lag_n    = lag;
        locked_n = locked;
        lost_n   = 1'b0;
        fail_n   = 1'b0;
        fill_n   = fill_cnt;
        tmo_n    = tmo_cnt;
        win_n    = win_cnt;
        miss_n   = miss_cnt;
        cnt_n    = cnt;
        // A miss on the wrap cycle is the first miss of the new window.
        miss_sum = wrap ? MISS_W'(miss_now) : miss_cnt + MISS_W'(miss_now);

        if (start) begin
            state_n  = S_FILL;
            locked_n = 1'b0;
            fill_n   = '0;
            tmo_n    = '0;
            win_n    = '0;
            miss_n   = '0;
            for (int k = 0; k <= MAX_LEN; k++) begin
                cnt_n[k] = '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                end
                S_FILL: begin
                    if (fill_cnt == FILL_LAST) begin
                        state_n = S_SEARCH;
                    end else begin
                        fill_n = fill_cnt + 1'b1;
                    end
                end
                S_SEARCH: begin
                    for (int k = 0; k <= MAX_LEN; k++) begin
                        if (!match[k]) begin
                            cnt_n[k] = '0;
                        end else if (cnt[k] == CNT_MAX) begin
                            cnt_n[k] = CNT_MAX;
                        end else begin
                            cnt_n[k] = cnt[k] + 1'b1;
                        end
                    end
                    if (hit) begin
                        state_n  = S_LOCKED;
                        lag_n    = hit_k;
                        locked_n = 1'b1;
                        win_n    = '0;
                        miss_n   = '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state_n = S_IDLE;
                        fail_n  = 1'b1;
                        tmo_n   = '0;
                    end else begin
                        tmo_n = tmo_cnt + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (miss_sum >= MISS_LOSS) begin
                        // History is still valid, so go straight back to searching.
                        state_n  = S_SEARCH;
                        locked_n = 1'b0;
                        lost_n   = 1'b1;
                        tmo_n    = '0;
                        win_n    = '0;
                        miss_n   = '0;
                        for (int k = 0; k <= MAX_LEN; k++) begin
                            cnt_n[k] = '0;
                        end
                    end else begin
                        win_n  = wrap ? '0 : win_cnt + 1'b1;
                        miss_n = miss_sum;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lag        <= '0;
            locked     <= 1'b0;
            lost_pulse <= 1'b0;
            fail_pulse <= 1'b0;
            fill_cnt   <= '0;
            tmo_cnt    <= '0;
            win_cnt    <= '0;
            miss_cnt   <= '0;
            for (int k = 0; k <= MAX_LEN; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            lag        <= lag_n;
            locked     <= locked_n;
            lost_pulse <= lost_n;
            fail_pulse <= fail_n;
            fill_cnt   <= fill_n;
            tmo_cnt    <= tmo_n;
            win_cnt    <= win_n;
            miss_cnt   <= miss_n;
            cnt        <= cnt_n;
        end
    end

    assign busy = (state == S_FILL) || (state == S_SEARCH);

endmodule

// File: tb/tb_xbit_delay_detector.sv
// tb/tb_xbit_delay_detector.sv - self-checking bench for xbit_delay_detector
module tb_xbit_delay_detector;

    localparam int MAX_LEN  = 15;
    localparam int OFFSET   = 2;
    localparam int WIN      = 32;
    localparam int LOSS     = 4;
    localparam int TIMEOUT  = 1024;
    localparam int FILL_CYC = MAX_LEN + OFFSET + 1;
    localparam int LOCK_CYC = FILL_CYC + WIN;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ref_bit = 1'b0;
    logic       dly_bit = 1'b0;
    logic [3:0] lag;
    logic       locked;
    logic       busy;
    logic       lost_pulse;
    logic       fail_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0]  prbs;
    logic [31:0] rhist = '0;
    int          dly = 7;
    bit          dly_zero = 1'b0;

    xbit_delay_detector #(
        .MAX_LEN (MAX_LEN),
        .OFFSET  (OFFSET),
        .WIN     (WIN),
        .LOSS    (LOSS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ref_bit    (ref_bit),
        .dly_bit    (dly_bit),
        .lag        (lag),
        .locked     (locked),
        .busy       (busy),
        .lost_pulse (lost_pulse),
        .fail_pulse (fail_pulse)
    );

    always #5 clk = ~clk;

    // PRBS7 reference and an ideal delay line modelling the shifter.
    initial begin : stim_gen
        prbs = 7'($urandom_range(1, 127));
        forever begin
            @(negedge clk);
            rhist   = {rhist[30:0], ref_bit};
            prbs    = {prbs[5:0], prbs[6] ^ prbs[5]};
            ref_bit = prbs[0];
            dly_bit = dly_zero ? 1'b0 : rhist[dly-1];
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Returns at the first sampling point after the edge that captured start.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_to_lock(input int bound, output int cyc, output int busy_cnt);
        cyc = 0;
        busy_cnt = 0;
        while (locked !== 1'b1 && cyc < bound) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_lost(input int bound, output int cyc);
        cyc = 0;
        while (lost_pulse !== 1'b1 && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Start a fresh search with a given shifter length and expect lock at that length.
    task automatic lock_at(input string tag, input int len);
        int cyc, bc;
        dly = len + OFFSET;
        pulse_start();
        run_to_lock(LOCK_CYC + 20, cyc, bc);
        check_eq({tag, "_locked"}, locked, 1);
        check_eq({tag, "_latency"}, cyc, LOCK_CYC);
        check_eq({tag, "_lag"}, lag, len);
    endtask

    initial begin : main
        int cyc, bc, fails, fail_at, lock_seen, drops, a, b;

        // Reset state.
        repeat (3) @(negedge clk);
        check_eq("reset_outs", {lag, locked, busy, lost_pulse, fail_pulse}, 0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("idle_no_start", {locked, busy}, 0);

        // Test 1: length 5, full latency and busy profile.
        dly = 7;
        pulse_start();
        check_eq("t1_busy_after_start", busy, 1);
        run_to_lock(LOCK_CYC + 20, cyc, bc);
        check_eq("t1_locked", locked, 1);
        check_eq("t1_within_bound", cyc <= LOCK_CYC + 2, 1);
        check_eq("t1_busy_cycles", bc, LOCK_CYC);
        check_eq("t1_lag", lag, 5);
        check_eq("t1_busy_low", busy, 0);
        drops = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (locked !== 1'b1 || lost_pulse !== 1'b0) drops++;
        end
        check_eq("t1_stays_locked", drops, 0);

        // Test 3: step the delay 5 -> 6 while locked.
        dly = 8;
        wait_lost(2 * WIN, cyc);
        check_eq("t3_lost_pulse", lost_pulse, 1);
        check_eq("t3_unlocked", locked, 0);
        check_eq("t3_busy", busy, 1);
        @(negedge clk);
        check_eq("t3_lost_one_cycle", lost_pulse, 0);
        run_to_lock(WIN + 20, cyc, bc);
        check_eq("t3_relocked", locked, 1);
        check_eq("t3_no_fill", cyc <= WIN + 1, 1);
        check_eq("t3_lag", lag, 6);

        // Test 2: boundary lengths.
        lock_at("t2_min", 0);
        lock_at("t2_max", MAX_LEN);

        // Randomized lengths and randomized delay steps.
        for (int t = 0; t < 4; t++) begin
            a = $urandom_range(0, MAX_LEN);
            prbs = 7'($urandom_range(1, 127));
            repeat ($urandom_range(0, 7)) @(negedge clk);
            lock_at("rnd_lock", a);
            b = $urandom_range(0, MAX_LEN - 1);
            if (b >= a) b++;
            dly = b + OFFSET;
            wait_lost(2 * WIN, cyc);
            check_eq("rnd_lost", lost_pulse, 1);
            run_to_lock(WIN + 20, cyc, bc);
            check_eq("rnd_relock", locked, 1);
            check_eq("rnd_relag", lag, b);
        end

        // Test 4: delayed stream stuck at zero never locks and times out.
        dly_zero = 1'b1;
        pulse_start();
        fails = 0;
        fail_at = -1;
        lock_seen = 0;
        for (int c = 0; c < FILL_CYC + TIMEOUT + 20; c++) begin
            if (fail_pulse === 1'b1) begin
                fails++;
                if (fail_at < 0) fail_at = c;
            end
            if (locked === 1'b1) lock_seen++;
            @(negedge clk);
        end
        check_eq("t4_fail_count", fails, 1);
        check_eq("t4_fail_time", fail_at, FILL_CYC + TIMEOUT);
        check_eq("t4_no_lock", lock_seen, 0);
        check_eq("t4_idle", busy, 0);
        dly_zero = 1'b0;

        // Test 5: restart while locked; lag holds until the new lock.
        lock_at("t5_pre", 9);
        dly = 3 + OFFSET;
        pulse_start();
        check_eq("t5_unlocked", locked, 0);
        check_eq("t5_busy", busy, 1);
        check_eq("t5_lag_hold", lag, 9);
        repeat (LOCK_CYC - 1) @(negedge clk);
        check_eq("t5_lag_hold_late", {locked, lag}, 9);
        @(negedge clk);
        check_eq("t5_new_lag", {locked, lag}, {1'b1, 4'd3});
        // Start coincident with the lock event.
        pulse_start();
        repeat (LOCK_CYC - 1) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("t5_coincident_unlocked", locked, 0);
        check_eq("t5_coincident_busy", busy, 1);
        run_to_lock(LOCK_CYC + 20, cyc, bc);
        check_eq("t5_coincident_relock", cyc, LOCK_CYC);

        // Test 6: asynchronous reset during SEARCH, then during LOCKED.
        pulse_start();
        repeat (FILL_CYC + 7) @(negedge clk);
        check_eq("t6_in_search", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_eq("t6_search_rst", {lag, locked, busy, lost_pulse, fail_pulse}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lock_seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (busy !== 1'b0 || locked !== 1'b0) lock_seen++;
        end
        check_eq("t6_idle_after_search_rst", lock_seen, 0);
        lock_at("t6_pre", 12);
        #2 rst_n = 1'b0;
        #1 check_eq("t6_locked_rst", {lag, locked, busy, lost_pulse, fail_pulse}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("t6_idle_after_locked_rst", {lag, locked, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
